// File: rtl/wb_stage.sv
// M/W pipeline register for the MIPS core: captures memory-stage results,
// extracts and extends sub-word loads, and drives the GRF write port.
module wb_stage #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int LINK_OFS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_alu,
    input  logic [WIDTH-1:0] m_dm,
    input  logic [WIDTH-1:0] m_hi,
    input  logic [WIDTH-1:0] m_lo,
    input  logic [WIDTH-1:0] m_pc,
    input  logic [15:0]      m_imm,
    input  logic [2:0]       m_src,
    input  logic [2:0]       m_ld,
    input  logic             m_we,
    input  logic [AW-1:0]    m_wa,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] w_wd,
    output logic [AW-1:0]    w_wa,
    output logic             w_we,
    output logic             w_valid,
    output logic [31:0]      retire_cnt
);

    localparam int OFFW = $clog2(WIDTH / 8);

    typedef enum logic [2:0] {
        SRC_ALU  = 3'd0,
        SRC_LOAD = 3'd1,
        SRC_LINK = 3'd2,
        SRC_HI   = 3'd3,
        SRC_LO   = 3'd4,
        SRC_LUI  = 3'd5
    } src_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_e;

    logic [OFFW-1:0]  off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] link_val;
    logic [WIDTH-1:0] lui_val;
    logic [WIDTH-1:0] next_wd;
    logic             next_we;

    assign off = m_alu[OFFW-1:0];

    // Halfword lane ignores off[0]; misalignment is trapped upstream.
    always_comb begin
        byte_sel = m_dm[{off, 3'b000} +: 8];
        half_sel = m_dm[{off[OFFW-1:1], 4'b0000} +: 16];
    end

    always_comb begin
        load_val = m_dm;
        case (m_ld)
            LD_B:    load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_BU:   load_val = {{(WIDTH-8){1'b0}}, byte_sel};
            LD_H:    load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LD_HU:   load_val = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_val = m_dm;
        endcase
    end

    assign link_val = m_pc + WIDTH'(LINK_OFS);

    generate
        if (WIDTH > 32) begin : g_lui_wide
            assign lui_val = {{(WIDTH-32){m_imm[15]}}, m_imm, 16'h0000};
        end else begin : g_lui_narrow
            assign lui_val = {m_imm, 16'h0000};
        end
    endgenerate

    always_comb begin
        next_wd = m_alu;
        case (m_src)
            SRC_LOAD: next_wd = load_val;
            SRC_LINK: next_wd = link_val;
            SRC_HI:   next_wd = m_hi;
            SRC_LO:   next_wd = m_lo;
            SRC_LUI:  next_wd = lui_val;
            default:  next_wd = m_alu;
        endcase
    end

    assign next_we = m_we & m_valid & (m_wa != '0);

    // Counter sees the slot leaving W, so a flush of a stalled valid entry still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_wd       <= '0;
            w_wa       <= '0;
            w_we       <= 1'b0;
            w_valid    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (w_valid && (!stall || flush))
                retire_cnt <= retire_cnt + 32'd1;
            if (flush) begin
                w_wd    <= '0;
                w_wa    <= '0;
                w_we    <= 1'b0;
                w_valid <= 1'b0;
            end else if (!stall) begin
                w_wd    <= next_wd;
                w_wa    <= m_wa;
                w_we    <= next_we;
                w_valid <= m_valid;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-cycle vectors plus
// hand-written stall, flush, counter-wrap and async-reset sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_alu, m_dm, m_hi, m_lo, m_pc;
    logic [15:0] m_imm;
    logic [2:0]  m_src, m_ld;
    logic        m_we;
    logic [4:0]  m_wa;
    logic        stall, flush;
    logic [31:0] w_wd;
    logic [4:0]  w_wa;
    logic        w_we, w_valid;
    logic [31:0] retire_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        mv;
    logic [31:0] ecnt;

    wb_stage #(.WIDTH(32), .AW(5), .LINK_OFS(8)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_alu(m_alu), .m_dm(m_dm),
        .m_hi(m_hi), .m_lo(m_lo), .m_pc(m_pc), .m_imm(m_imm), .m_src(m_src),
        .m_ld(m_ld), .m_we(m_we), .m_wa(m_wa), .stall(stall), .flush(flush),
        .w_wd(w_wd), .w_wa(w_wa), .w_we(w_we), .w_valid(w_valid),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [2:0]  ld;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        we;
        logic [4:0]  wa;
        logic        valid;
        logic [31:0] e_wd;
        logic        e_we;
        logic [4:0]  e_wa;
        logic        e_valid;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge, updating the bench's own W-valid and retire models.
    task automatic step();
        if (mv && (!stall || flush)) ecnt = ecnt + 32'd1;
        if (flush) mv = 1'b0;
        else if (!stall) mv = m_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] src, input logic [31:0] alu,
                         input logic we, input logic [4:0] wa, input logic valid);
        m_src = src; m_ld = 3'd0; m_alu = alu; m_we = we; m_wa = wa; m_valid = valid;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"}, w_wd, 32'h0);
        check({tag, "_wa"}, {27'h0, w_wa}, 32'h0);
        check({tag, "_we"}, {31'h0, w_we}, 32'h0);
        check({tag, "_valid"}, {31'h0, w_valid}, 32'h0);
        check({tag, "_cnt"}, retire_cnt, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 3'd0, 32'h12345678, 32'h0,        32'h0,        16'h0,    1'b1, 5'd5,  1'b1, 32'h12345678, 1'b1, 5'd5,  1'b1};
        vecs[1]  = '{3'd1, 3'd1, 32'h00000003, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd7,  1'b1, 32'hFFFFFF80, 1'b1, 5'd7,  1'b1};
        vecs[2]  = '{3'd1, 3'd2, 32'h00000001, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd8,  1'b1, 32'h0000007F, 1'b1, 5'd8,  1'b1};
        vecs[3]  = '{3'd1, 3'd3, 32'h00000002, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd9,  1'b1, 32'hFFFF80FF, 1'b1, 5'd9,  1'b1};
        vecs[4]  = '{3'd1, 3'd4, 32'h00000000, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd10, 1'b1, 32'h00007F01, 1'b1, 5'd10, 1'b1};
        vecs[5]  = '{3'd1, 3'd1, 32'h00000000, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd11, 1'b1, 32'h00000001, 1'b1, 5'd11, 1'b1};
        vecs[6]  = '{3'd1, 3'd3, 32'h00000003, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd12, 1'b1, 32'hFFFF80FF, 1'b1, 5'd12, 1'b1};
        vecs[7]  = '{3'd1, 3'd0, 32'h00000002, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd13, 1'b1, 32'h80FF7F01, 1'b1, 5'd13, 1'b1};
        vecs[8]  = '{3'd1, 3'd6, 32'h00000001, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd14, 1'b1, 32'h80FF7F01, 1'b1, 5'd14, 1'b1};
        vecs[9]  = '{3'd2, 3'd0, 32'h0,        32'h0,        32'h00003000, 16'h0,    1'b1, 5'd31, 1'b1, 32'h00003008, 1'b1, 5'd31, 1'b1};
        vecs[10] = '{3'd2, 3'd0, 32'h0,        32'h0,        32'hFFFFFFFC, 16'h0,    1'b1, 5'd31, 1'b1, 32'h00000004, 1'b1, 5'd31, 1'b1};
        vecs[11] = '{3'd5, 3'd0, 32'h0,        32'h0,        32'h0,        16'hABCD, 1'b1, 5'd2,  1'b1, 32'hABCD0000, 1'b1, 5'd2,  1'b1};
        vecs[12] = '{3'd3, 3'd0, 32'h0,        32'h0,        32'h0,        16'h0,    1'b1, 5'd3,  1'b1, 32'hDEADBEEF, 1'b1, 5'd3,  1'b1};
        vecs[13] = '{3'd4, 3'd0, 32'h0,        32'h0,        32'h0,        16'h0,    1'b1, 5'd4,  1'b1, 32'hCAFEF00D, 1'b1, 5'd4,  1'b1};
        vecs[14] = '{3'd7, 3'd0, 32'h55AA55AA, 32'h0,        32'h0,        16'h0,    1'b1, 5'd6,  1'b1, 32'h55AA55AA, 1'b1, 5'd6,  1'b1};
        vecs[15] = '{3'd0, 3'd0, 32'h00000001, 32'h0,        32'h0,        16'h0,    1'b1, 5'd0,  1'b1, 32'h00000001, 1'b0, 5'd0,  1'b1};
        vecs[16] = '{3'd0, 3'd0, 32'h00000002, 32'h0,        32'h0,        16'h0,    1'b0, 5'd9,  1'b1, 32'h00000002, 1'b0, 5'd9,  1'b1};
        vecs[17] = '{3'd1, 3'd2, 32'h00000002, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd15, 1'b1, 32'h000000FF, 1'b1, 5'd15, 1'b1};
        vecs[18] = '{3'd1, 3'd4, 32'h00000003, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd16, 1'b1, 32'h000080FF, 1'b1, 5'd16, 1'b1};
        vecs[19] = '{3'd1, 3'd5, 32'h00000003, 32'h80FF7F01, 32'h0,        16'h0,    1'b1, 5'd17, 1'b1, 32'h80FF7F01, 1'b1, 5'd17, 1'b1};
        vecs[20] = '{3'd0, 3'd0, 32'h00000003, 32'h0,        32'h0,        16'h0,    1'b1, 5'd3,  1'b0, 32'h00000003, 1'b0, 5'd3,  1'b0};

        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_alu = '0; m_dm = '0; m_pc = '0; m_imm = '0;
        m_hi = 32'hDEADBEEF; m_lo = 32'hCAFEF00D;
        m_src = '0; m_ld = '0; m_we = 1'b0; m_wa = '0;
        mv = 1'b0; ecnt = '0;

        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            m_src = vecs[i].src; m_ld = vecs[i].ld; m_alu = vecs[i].alu; m_dm = vecs[i].dm;
            m_pc = vecs[i].pc; m_imm = vecs[i].imm; m_we = vecs[i].we; m_wa = vecs[i].wa;
            m_valid = vecs[i].valid;
            step();
            check($sformatf("v%0d_wd", i), w_wd, vecs[i].e_wd);
            check($sformatf("v%0d_we", i), {31'h0, w_we}, {31'h0, vecs[i].e_we});
            check($sformatf("v%0d_wa", i), {27'h0, w_wa}, {27'h0, vecs[i].e_wa});
            check($sformatf("v%0d_valid", i), {31'h0, w_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_cnt", i), retire_cnt, ecnt);
        end

        // Stall for three cycles while M changes underneath.
        drive(3'd0, 32'h11, 1'b1, 5'd4, 1'b1);
        step();
        check("stall_pre_wd", w_wd, 32'h11);
        stall = 1'b1;
        drive(3'd0, 32'h22, 1'b1, 5'd6, 1'b1);
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_wd", k), w_wd, 32'h11);
            check($sformatf("stall%0d_wa", k), {27'h0, w_wa}, 32'd4);
            check($sformatf("stall%0d_we", k), {31'h0, w_we}, 32'd1);
            check($sformatf("stall%0d_cnt", k), retire_cnt, ecnt);
        end
        stall = 1'b0;
        step();
        check("release_wd", w_wd, 32'h22);
        check("release_wa", {27'h0, w_wa}, 32'd6);
        check("release_cnt", retire_cnt, ecnt);

        // Flush beats stall; the displaced valid entry still retires.
        stall = 1'b1; flush = 1'b1;
        drive(3'd0, 32'h33, 1'b1, 5'd7, 1'b1);
        step();
        check("sflush_wd", w_wd, 32'h0);
        check("sflush_wa", {27'h0, w_wa}, 32'h0);
        check("sflush_we", {31'h0, w_we}, 32'h0);
        check("sflush_valid", {31'h0, w_valid}, 32'h0);
        check("sflush_cnt", retire_cnt, ecnt);
        stall = 1'b0; flush = 1'b0;
        step();
        check("after_flush_wd", w_wd, 32'h33);
        check("after_flush_cnt", retire_cnt, ecnt);

        // Counter wrap from an injected all-ones value.
        drive(3'd0, 32'h44, 1'b1, 5'd2, 1'b1);
        step();
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1 release dut.retire_cnt;
        #1 check("preload_cnt", retire_cnt, 32'hFFFFFFFF);
        ecnt = 32'hFFFFFFFF;
        step();
        check("wrap_cnt", retire_cnt, 32'h0);

        // Async reset asserted mid-stall, between edges.
        drive(3'd0, 32'h55, 1'b1, 5'd3, 1'b1);
        step();
        stall = 1'b1;
        step();
        check("pre_areset_wd", w_wd, 32'h55);
        #2 reset = 1'b1;
        #1 check_all_zero("areset");
        @(posedge clk); #1;
        check_all_zero("areset_edge");
        reset = 1'b0; stall = 1'b0;
        mv = 1'b0; ecnt = '0;
        drive(3'd0, 32'h66, 1'b1, 5'd1, 1'b1);
        step();
        check("post_reset_wd", w_wd, 32'h66);
        check("post_reset_we", {31'h0, w_we}, 32'd1);
        check("post_reset_cnt", retire_cnt, ecnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
